// File: rtl/mem_stall_responder_pkg.sv
// Shared types and widths for the stalling memory responder.
package mem_stall_responder_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mem_stall_responder_mem_array.sv
// Single-port word storage: synchronous write, combinational read, never reset.
module mem_array
  import mem_stall_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_reg[idx] <= wdata;
    end
  end

  assign rdata = mem_reg[idx];

endmodule

// File: rtl/mem_stall_responder.sv
// Fixed-latency memory responder: freezes the pipeline for LATENCY cycles per access,
// then commits the write or presents read data with a one-cycle valid pulse.
module mem_stall_responder
  import mem_stall_responder_pkg::*;
#(
  parameter int LATENCY = 3,
  parameter int DEPTH   = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [31:0]       addr_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              stall_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              op_write_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] data_reg;
  logic              valid_reg;

  logic              request;
  logic              enter_done;
  logic              access_write;
  logic [IDX_W-1:0]  addr_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_we;
  logic              unused_addr_bits;

  assign request  = MemRead_i | MemWrite_i;
  assign addr_idx = addr_i[IDX_W+1:2];
  assign unused_addr_bits = ^{addr_i[31:IDX_W+2], addr_i[1:0]};

  // With LATENCY=1 the access completes straight out of IDLE, so the live
  // inputs address the storage; otherwise the latched copies do.
  assign access_write = (state_reg == IDLE) ? MemWrite_i : op_write_reg;
  assign mem_idx      = (state_reg == IDLE) ? addr_idx   : idx_reg;
  assign mem_wdata    = (state_reg == IDLE) ? data_i     : wdata_reg;

  assign enter_done = !rst_i &&
                      (((state_reg == IDLE) && request && (LATENCY == 1)) ||
                       ((state_reg == BUSY) && (cnt_reg == CNT_ONE)));
  assign mem_we = enter_done && access_write;

  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      case (state_reg)
        IDLE:    stall_o = request;
        BUSY:    stall_o = 1'b1;
        default: stall_o = 1'b0;
      endcase
    end
  end

  mem_array #(
    .DEPTH (DEPTH)
  ) u_mem_array (
    .clk   (clk_i),
    .we    (mem_we),
    .idx   (mem_idx),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      op_write_reg <= 1'b0;
      idx_reg      <= '0;
      wdata_reg    <= '0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (request) begin
            op_write_reg <= MemWrite_i;
            idx_reg      <= addr_idx;
            wdata_reg    <= data_i;
            cnt_reg      <= CNT_LOAD;
            state_reg    <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_ONE) begin
            state_reg <= DONE;
          end
        end
        // Inputs still show the instruction just served, so DONE never re-arms.
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      if (enter_done && !access_write) begin
        data_reg  <= mem_rdata;
        valid_reg <= 1'b1;
      end
    end
  end

  assign data_o  = data_reg;
  assign valid_o = valid_reg;

endmodule
